// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the J/K modulo counter:
//   - default width and modulus
//   - op_e: the action selected at a clock edge, in priority order
//   - clamp_load(): saturates a load value into the count range
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  // Action taken at the next rising edge, highest priority first.
  typedef enum logic [1:0] {
    OP_CLEAR,
    OP_LOAD,
    OP_COUNT,
    OP_HOLD
  } op_e;

  // Loads at or above the modulus saturate to the top of the range.
  function automatic logic [31:0] clamp_load(input logic [31:0] d,
                                             input int unsigned modulus);
    if (d < modulus) return d;
    return modulus - 1;
  endfunction

endpackage : counter_pkg

// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff
// Single J/K flip-flop with synchronous active-low clear.
// Ports:
//   clk  in  rising-edge clock
//   clr  in  synchronous clear, active-low (q <- 0)
//   j    in  set / toggle input
//   k    in  reset / toggle input
//   q    out registered state
// j/k: 00 hold, 01 reset, 10 set, 11 toggle.
// -----------------------------------------------------------------------------
module jk_ff (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: state is written with non-blocking assignments so every flop in the
  // bank samples the pre-edge value of its neighbours' outputs.
  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule : jk_ff

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
// Synchronous modulo-MODULUS up/down counter built from a bank of jk_ff cells.
// The next count is chosen by priority (clear, load, count, hold); each cell
// is then driven in toggle form so it flips exactly where q and next differ.
// Ports:
//   clk   in  rising-edge clock
//   clr   in  synchronous clear, active-low (q <- 0, wrap <- 0)
//   en    in  count enable
//   up    in  direction: 1 increment, 0 decrement
//   load  in  parallel load strobe (overrides en/up)
//   d     in  load value, saturated to MODULUS-1
//   q     out current count (flip-flop outputs), always in 0..MODULUS-1
//   tc    out terminal count: a wrap happens at the next edge (combinational)
//   wrap  out registered one-cycle pulse following a wrapping edge
// -----------------------------------------------------------------------------
module jk_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Compares are done one bit wider so MODULUS = 2^WIDTH still fits LAST.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  op_e              op;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] toggle;
  logic             at_last;
  logic             at_zero;
  logic             wrap_nxt;

  assign q_ext   = {1'b0, q};
  assign at_last = (q_ext == LAST);
  assign at_zero = (q_ext == '0);

  // Action selection in priority order.
  always_comb begin
    if (!clr)      op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_COUNT;
    else           op = OP_HOLD;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    nxt_ext  = q_ext;
    wrap_nxt = 1'b0;
    unique case (op)
      // Clearing is done by the cells' own clr; keep j=k=0 meanwhile.
      OP_CLEAR: nxt_ext = q_ext;
      OP_LOAD:  nxt_ext = (WIDTH+1)'(clamp_load(32'(d), MODULUS));
      OP_COUNT: begin
        if (up) begin
          if (at_last) begin
            nxt_ext  = '0;
            wrap_nxt = 1'b1;
          end else begin
            nxt_ext  = q_ext + ONE;
          end
        end else begin
          if (at_zero) begin
            nxt_ext  = LAST;
            wrap_nxt = 1'b1;
          end else begin
            nxt_ext  = q_ext - ONE;
          end
        end
      end
      default:  nxt_ext = q_ext;
    endcase
  end

  // nxt_ext never exceeds LAST, so the top bit is always zero here.
  assign nxt = nxt_ext[WIDTH-1:0];

  // Toggle form: a cell flips exactly where the current and next values differ.
  assign toggle = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk (clk),
      .clr (clr),
      .j   (toggle[i]),
      .k   (toggle[i]),
      .q   (q[i])
    );
  end

  assign tc = en & ~load & ((up & at_last) | (~up & at_zero));

  // NOTE: clear is sampled on the clock edge only (synchronous), matching the
  // flip-flop cells, so q and wrap leave reset on the same edge.
  always_ff @(posedge clk) begin
    if (!clr) wrap <= 1'b0;
    else      wrap <= wrap_nxt;
  end

  // The field is only a carrier for the compare width; nothing else reads it.
  logic unused_top;
  assign unused_top = nxt_ext[WIDTH];

endmodule : jk_mod_counter

// File: tb/tb_jk_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_counter
// Directed walk through the counter's key behaviours followed by randomized
// cycles, all compared against a modular-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk;
  logic             clr;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int model_q     = 0;
  bit model_wrap  = 1'b0;
  bit model_valid = 1'b0;

  jk_mod_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check tc before the edge, advance the
  // model by the counter's rules, then check q and wrap after the edge.
  task automatic step(input bit c, input bit e, input bit u, input bit l,
                      input int dv);
    bit exp_tc;
    clr  = c;
    en   = e;
    up   = u;
    load = l;
    d    = WIDTH'(dv);
    #1;
    if (model_valid) begin
      exp_tc = e && !l && ((u && model_q == MODULUS - 1) || (!u && model_q == 0));
      check("tc", 32'(tc), 32'(exp_tc));
    end
    @(posedge clk);
    if (!c) begin
      model_q    = 0;
      model_wrap = 1'b0;
    end else if (l) begin
      model_q    = (dv < MODULUS) ? dv : MODULUS - 1;
      model_wrap = 1'b0;
    end else if (e) begin
      if (u) begin
        model_wrap = (model_q + 1 == MODULUS);
        model_q    = (model_q + 1) % MODULUS;
      end else begin
        model_wrap = (model_q == 0);
        model_q    = (model_q + MODULUS - 1) % MODULUS;
      end
    end else begin
      model_wrap = 1'b0;
    end
    model_valid = 1'b1;
    #1;
    check("q", 32'(q), 32'(model_q));
    check("wrap", 32'(wrap), 32'(model_wrap));
  endtask

  initial begin
    clr  = 1'b0;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    d    = '0;

    // Reset dominates load and enable; release holds q at 0.
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 7);
    check("reset_q", 32'(q), 32'd0);
    check("reset_tc_en0", 32'(tc), 32'(en & ~load & ~up));
    step(1, 0, 1, 0, 0);
    check("release_q", 32'(q), 32'd0);

    // Up count through the wrap: 1..9,0,1,2.
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    check("up_end_q", 32'(q), 32'd2);

    // Down count through the wrap: 1,0,9,8.
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    check("down_end_q", 32'(q), 32'd8);

    // Load beats enable; out-of-range loads saturate.
    step(1, 1, 1, 1, 4);
    check("load_prio_q", 32'(q), 32'd4);
    step(1, 0, 1, 1, 13);
    check("load_13_q", 32'(q), 32'd9);
    step(1, 0, 1, 1, 15);
    check("load_15_q", 32'(q), 32'd9);

    // Hold at 5, then alternate direction every cycle: 6,5,6,5.
    step(1, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    check("hold_q", 32'(q), 32'd5);
    for (int i = 0; i < 4; i++) step(1, 1, (i % 2 == 0), 0, 0);
    check("flip_end_q", 32'(q), 32'd5);

    // Clear on the edge that would have wrapped: no wrap pulse.
    step(1, 0, 1, 1, 9);
    step(0, 1, 1, 0, 0);
    check("clr_wrap_q", 32'(q), 32'd0);
    check("clr_wrap_w", 32'(wrap), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jk_mod_counter
